// File: rtl/ysyx_23060096_pkg.sv
// Shared writeback definitions: load-type encodings and the queue entry record.
package ysyx_23060096_pkg;

  localparam int WBU_AW = 5;
  localparam int WBU_DW = 32;

  typedef enum logic [2:0] {
    LD_PASS = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } ldtype_e;

  // Value is stored already formatted so the writeback path is a plain mux.
  typedef struct packed {
    logic              wen;
    logic [WBU_AW-1:0] rd;
    logic [WBU_DW-1:0] value;
  } wbu_entry_t;

endpackage

// File: rtl/ysyx_23060096_wbu_loadalign.sv
// Load formatter: byte/half select by offset, then sign or zero extension.
module ysyx_23060096_LoadAlign
  import ysyx_23060096_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            ldtype,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = raw[{addr_lo, 3'b000} +: 8];
    h = raw[{addr_lo[1], 4'b0000} +: 16];
    case (ldtype)
      LD_LB:   value = {{(DATA_WIDTH-8){b[7]}}, b};
      LD_LH:   value = {{(DATA_WIDTH-16){h[15]}}, h};
      LD_LBU:  value = {{(DATA_WIDTH-8){1'b0}}, b};
      LD_LHU:  value = {{(DATA_WIDTH-16){1'b0}}, h};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Writeback queue: formats results on entry, retires one per cycle to the
// register file and forwards the youngest pending value to decode.
module ysyx_23060096_wbu
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_ldtype,
  input  logic [1:0]            in_addr_lo,
  input  logic                  wb_stall,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] Ra,
  input  logic [ADDR_WIDTH-1:0] Rb,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic [DATA_WIDTH-1:0] fwd_a_data,
  output logic [DATA_WIDTH-1:0] fwd_b_data,
  output logic [31:0]           retire_cnt
);

  localparam int PW = $clog2(DEPTH);

  wbu_entry_t            q [DEPTH];
  wbu_entry_t            head, ent, fe;
  logic [PW:0]           wr_ptr, rd_ptr, count;
  logic [PW-1:0]         idx;
  logic                  full, empty, push, pop, live;
  logic [DATA_WIDTH-1:0] fmt;

  ysyx_23060096_LoadAlign #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .ldtype  (in_ldtype),
    .addr_lo (in_addr_lo),
    .raw     (in_data),
    .value   (fmt)
  );

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

  // Reset masks the queue so no stale entry can retire or forward.
  assign in_ready = rst || !full;
  assign push     = !rst && in_valid && !full;
  assign pop      = !rst && !empty && !wb_stall;
  assign head     = q[rd_ptr[PW-1:0]];

  always_comb begin
    ent       = '0;
    ent.wen   = in_wen;
    ent.rd    = WBU_AW'(in_rd);
    ent.value = WBU_DW'(fmt);
  end

  assign w_en  = pop && head.wen && (head.rd != '0);
  assign waddr = ADDR_WIDTH'(head.rd);
  assign wdata = DATA_WIDTH'(head.value);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      retire_cnt <= '0;
    end else begin
      if (push) begin
        q[wr_ptr[PW-1:0]] <= ent;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // Walk oldest to youngest so the last match wins; the head stays visible
  // in the cycle it pops because the register file only updates at the edge.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    idx        = '0;
    fe         = '0;
    live       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = rd_ptr[PW-1:0] + PW'(i);
      fe   = q[idx];
      live = !rst && ((PW+1)'(i) < count) && fe.wen && (fe.rd != '0);
      if (live && (fe.rd == WBU_AW'(Ra))) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = DATA_WIDTH'(fe.value);
      end
      if (live && (fe.rd == WBU_AW'(Rb))) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = DATA_WIDTH'(fe.value);
      end
    end
  end

endmodule
